// File: rtl/cpu_press_controller.sv
// cpu_press_controller: paces computer-player press decisions through a shared registered comparator.
module cpu_press_controller #(
  parameter int TICK_DIV       = 50,
  parameter int HOLDOFF_CYCLES = 8,
  parameter int W              = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         freeze,
  input  logic [W-1:0] difficulty,
  input  logic [W-1:0] rand_val,
  input  logic         cmp_result,
  output logic [W-1:0] cmp_a,
  output logic [W-1:0] cmp_b,
  output logic         press,
  output logic         busy,
  output logic [7:0]   press_count
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, LOAD, EVAL, PRESS, HOLD} state_t;
  state_t state, nxt;
  logic [PW-1:0] pre;
  logic [HW-1:0] hcnt;
  logic tick;
  assign tick = pre == PW'(TICK_DIV - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) pre <= '0;
    else pre <= (freeze || tick) ? '0 : pre + PW'(1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= nxt;
      busy  <= nxt != IDLE;
    end
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = (tick && enable) ? LOAD : IDLE;
      LOAD:    nxt = EVAL;
      EVAL:    nxt = cmp_result ? PRESS : IDLE;
      PRESS:   nxt = HOLD;
      HOLD:    nxt = (hcnt == HW'(1)) ? IDLE : HOLD;
      default: nxt = IDLE;
    endcase
    if (freeze) nxt = IDLE;
  end
  always_comb press = (state == PRESS) && !freeze;
  // Operands are latched only on the IDLE->LOAD edge so they stay stable through the comparator latency.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cmp_a       <= '0;
      cmp_b       <= '0;
      press_count <= '0;
      hcnt        <= '0;
    end else begin
      if (state == IDLE && nxt == LOAD) begin
        cmp_a <= difficulty;
        cmp_b <= rand_val;
      end
      if (press && !(&press_count)) press_count <= press_count + 8'd1;
      hcnt <= (state == PRESS) ? HW'(HOLDOFF_CYCLES) : (state == HOLD) ? hcnt - HW'(1) : hcnt;
    end
endmodule

// File: tb/tb_cpu_press_controller.sv
// tb_cpu_press_controller: randomized check of cpu_press_controller against a sequence-position model.
module tb_cpu_press_controller;
  localparam int TD = 4, H = 3, W = 10;
  logic clk = 0, reset = 1, enable = 0, freeze = 0, cmp_result;
  logic [W-1:0] difficulty = 0, rand_val = 0, cmp_a, cmp_b;
  logic press, busy;
  logic [7:0] press_count;
  int vecs = 0, errs = 0;
  int m_pre, m_pos, m_cnt;
  logic [W-1:0] m_a, m_b;
  always #5 clk = ~clk;
  // Stand-in for the registered A>B comparator.
  always @(posedge clk or posedge reset) cmp_result <= reset ? 1'b0 : (cmp_a > cmp_b);
  cpu_press_controller #(.TICK_DIV(TD), .HOLDOFF_CYCLES(H), .W(W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .freeze(freeze),
    .difficulty(difficulty), .rand_val(rand_val), .cmp_result(cmp_result),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .press(press), .busy(busy), .press_count(press_count)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_all();
    chk("press", 32'(press), 32'(m_pos == 3 && !freeze));
    chk("busy", 32'(busy), 32'(m_pos != 0));
    chk("press_count", 32'(press_count), m_cnt);
    chk("cmp_a", 32'(cmp_a), 32'(m_a));
    chk("cmp_b", 32'(cmp_b), 32'(m_b));
  endtask
  task automatic mreset();
    m_pre = 0; m_pos = 0; m_cnt = 0; m_a = 0; m_b = 0;
  endtask
  // m_pos: 0 idle, 1 operands presented, 2 result sampled, 3 press, 4..3+H holdoff.
  task automatic mstep();
    bit tk;
    tk = m_pre == TD - 1;
    m_pre = freeze ? 0 : (m_pre + 1) % TD;
    if (freeze) m_pos = 0;
    else if (m_pos == 0) begin
      if (tk && enable) begin
        m_pos = 1; m_a = difficulty; m_b = rand_val;
      end
    end else if (m_pos == 2) m_pos = (m_a > m_b) ? 3 : 0;
    else if (m_pos == 3) begin
      m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      m_pos = 4;
    end else m_pos = (m_pos == 3 + H) ? 0 : m_pos + 1;
  endtask
  task automatic drive(input int mode, input bit quiet, input bit frz_eval);
    enable = quiet ? 1'b1 : ($urandom_range(0, 7) != 0);
    freeze = quiet ? 1'b0 : ($urandom_range(0, 15) == 0);
    if (frz_eval && m_pos == 2) freeze = 1'b1;
    case (mode)
      0: begin difficulty = W'($urandom); rand_val = W'($urandom); end
      1: begin difficulty = W'(512 + $urandom_range(0, 511)); rand_val = W'($urandom_range(0, 511)); end
      2: begin difficulty = W'($urandom); rand_val = difficulty; end
      3: begin difficulty = '1; rand_val = W'($urandom_range(1021, 1023)); end
      default: begin difficulty = '0; rand_val = W'($urandom); end
    endcase
  endtask
  task automatic cycle(input int mode, input bit quiet, input bit frz_eval);
    @(negedge clk);
    check_all();
    drive(mode, quiet, frz_eval);
    mstep();
  endtask
  initial begin
    mreset();
    @(negedge clk);
    check_all();
    reset = 0;
    drive(1, 1, 0);
    mstep();
    repeat (40) cycle(1, 1, 0);
    for (int k = 0; k < 5; k++) repeat (60) cycle(k, 0, 0);
    repeat (200) cycle(1, 0, 1);
    for (int s = 0; s < 60; s++) begin
      int md;
      md = $urandom_range(0, 4);
      repeat (50) cycle(md, 0, 0);
    end
    for (int i = 0; i < 50 && m_pos < 4; i++) cycle(1, 1, 0);
    chk("reach_holdoff", 32'(m_pos >= 4), 32'd1);
    @(posedge clk);
    #2 reset = 1;
    #1;
    chk("rst_press", 32'(press), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_count", 32'(press_count), 0);
    chk("rst_cmp_a", 32'(cmp_a), 0);
    chk("rst_cmp_b", 32'(cmp_b), 0);
    mreset();
    @(negedge clk);
    check_all();
    reset = 0;
    drive(1, 1, 0);
    mstep();
    repeat (2700) cycle(1, 1, 0);
    chk("saturated", 32'(press_count), 32'd255);
    repeat (300) cycle(0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/cpu_press_controller.md
Name: cpu_press_controller

Overview:
Sequences the shared registered 10-bit comparator that decides when the computer player "presses" in the tug-of-war game. A prescaler paces decision attempts. On each attempt the block loads the difficulty setting and an LFSR sample into the comparator and waits out its one-cycle latency. On a true result it emits a single-cycle press pulse, followed by a holdoff window. Sits between the switch/LFSR sources and the playfield logic that consumes the computer's press.

Parameters:
TICK_DIV, 50, clocks between decision attempts (>=2)
HOLDOFF_CYCLES, 8, idle clocks forced after each press (>=1)
W, 10, operand width (matches comparator)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  game running; attempts only start while high
freeze  input  1  game over / round end; aborts sequence, suppresses press
difficulty  input  W  switch setting, comparator A operand
rand_val  input  W  LFSR sample, comparator B operand
cmp_result  input  1  registered comparator output (A > B), valid one clock after operands
cmp_a  output  W  operand A driven to comparator
cmp_b  output  W  operand B driven to comparator
press  output  1  one-cycle computer press pulse
busy  output  1  high in any state other than IDLE
press_count  output  8  saturating count of presses since reset

Behaviour:
- Reset (async): state=IDLE; cmp_a=0, cmp_b=0, press=0, busy=0, press_count=0; prescaler=0; holdoff counter=0.
- Prescaler counts 0..TICK_DIV-1 and wraps. tick=1 when count==TICK_DIV-1. While freeze=1 the prescaler is held at 0.
- States: IDLE, LOAD, EVAL, PRESS, HOLDOFF.
- IDLE: if tick & enable & !freeze -> cmp_a<=difficulty, cmp_b<=rand_val, go LOAD. Operands are captured on this edge only and held stable afterwards.
- LOAD: operands are presented to the comparator for one cycle. Always go EVAL.
- EVAL: sample cmp_result. If 1 -> PRESS. If 0 -> IDLE.
- PRESS: press=1 for exactly this cycle. press_count increments, saturating at 255. Load holdoff counter with HOLDOFF_CYCLES and go HOLDOFF.
- HOLDOFF: decrement the counter each cycle. At 0 -> IDLE. Length is exactly HOLDOFF_CYCLES cycles.
- Latency: for a tick at cycle t in IDLE, LOAD=t+1, EVAL=t+2, press high at t+3.
- Ticks arriving outside IDLE are dropped, not queued.
- freeze=1 in any state: next state is IDLE, press forced 0 in that same cycle, cmp_a/cmp_b hold their values, press_count is unchanged.
- enable falling mid-sequence does not abort; the sequence completes. Only freeze aborts.
- difficulty=0 never presses. difficulty=all-ones presses unless rand_val=all-ones. Equal operands never press (strict >).
- busy is registered with state and is 1 in LOAD/EVAL/PRESS/HOLDOFF.
- Reset asserted mid-sequence returns all outputs to reset values immediately.

Test Plan:
- TICK_DIV=4, HOLDOFF_CYCLES=3. Release reset, enable=1, difficulty=512, rand_val=2 -> press high for one cycle 3 clocks after each tick; next tick at or after IDLE re-entry; press_count increments 1,2,3.
- difficulty=2, rand_val=512 -> cmp_a=2, cmp_b=512 seen in LOAD; EVAL returns to IDLE; press never asserts; busy pulses 2 cycles per tick.
- difficulty=512, rand_val=512 (equal) -> no press. Then difficulty=1023, rand_val=1023 -> no press; rand_val=1022 -> press.
- Raise freeze during the EVAL cycle with cmp_result=1 -> press stays 0, state is IDLE next cycle, press_count unchanged, prescaler held at 0 until freeze drops.
- Assert reset during HOLDOFF -> press=0, busy=0, press_count=0, cmp_a=cmp_b=0 without waiting for a clock edge.
- Force 300 presses -> press_count saturates at 255 and stays there.
